// File: rtl/mips_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_C = 2'd1,
    RESP_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    DBG  = 2'd2
  } arb_grant_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_age.sv
// Starvation counter for the debug port: counts cycles a pending request
// goes ungranted, saturating at MAX_WAIT, and flags when the limit is reached.
module dmem_arb_age #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pending,
  input  logic granted,
  output logic expired
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!pending || granted) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign expired = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core load/store port and a debug port.
// Optional build macro DMEM_ARB_STATS_EN adds saturating grant/conflict counters.
//
// state  | meaning
// IDLE   | grants are made only here
// RESP_C | core read data returning from RAM
// RESP_D | debug read data returning from RAM
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_core_grants,
  output logic [15:0]       stat_dbg_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  arb_state_t state, state_nxt;
  arb_grant_t grant;
  logic       expired;

  dmem_arb_age #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk     (clk),
    .rst     (rst),
    .pending (dbg_valid),
    .granted (grant == DBG),
    .expired (expired)
  );

  // An expired debug request overrides the core's fixed priority.
  always_comb begin
    grant = NONE;
    if (state == IDLE) begin
      if (dbg_valid && expired)  grant = DBG;
      else if (core_req)         grant = CORE;
      else if (dbg_valid)        grant = DBG;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      CORE: begin
        mem_en    = 1'b1;
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      DBG: begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = IDLE;
    if (grant == CORE && !core_we)     state_nxt = RESP_C;
    else if (grant == DBG && !dbg_we)  state_nxt = RESP_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The held core_req in RESP_C is the one just served, so it must not stall.
  assign core_stall = core_req && (state != RESP_C) && !(grant == CORE && core_we);
  assign core_rdata = (state == RESP_C) ? mem_rdata : '0;
  assign dbg_ready  = (grant == DBG);
  assign dbg_rvalid = (state == RESP_D);
  assign dbg_rdata  = (state == RESP_D) ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_core_grants <= '0;
      stat_dbg_grants  <= '0;
      stat_conflicts   <= '0;
    end else begin
      if (grant == CORE) stat_core_grants <= sat_inc16(stat_core_grants);
      if (grant == DBG)  stat_dbg_grants  <= sat_inc16(stat_dbg_grants);
      if (state == IDLE && core_req && dbg_valid)
        stat_conflicts <= sat_inc16(stat_conflicts);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural RAM on the mem_* port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        dbg_valid, dbg_ready, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_core_grants, stat_dbg_grants, stat_conflicts;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] core_q[$];
  logic [31:0] dbg_q[$];
  logic [31:0] ram [0:255];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .dbg_valid  (dbg_valid),
    .dbg_ready  (dbg_ready),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core_grants (stat_core_grants),
    .stat_dbg_grants  (stat_dbg_grants),
    .stat_conflicts   (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr[9:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_mem_en"},     32'(mem_en), 32'd0);
    chk({name, "_core_stall"}, 32'(core_stall), 32'd0);
    chk({name, "_dbg_ready"},  32'(dbg_ready), 32'd0);
    chk({name, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
    chk({name, "_rdata"},      core_rdata | dbg_rdata | mem_addr | mem_wdata, 32'd0);
  endtask

  // Monitor: every read response the DUT presents is checked against the queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (dbg_rvalid) begin
          if (dbg_q.size() == 0) chk("dbg_resp_unexpected", 32'd1, 32'd0);
          else begin
            e = dbg_q.pop_front();
            chk("dbg_rdata", dbg_rdata, e);
          end
        end
        if (core_req && !core_we && !core_stall) begin
          if (core_q.size() == 0) chk("core_resp_unexpected", 32'd1, 32'd0);
          else begin
            e = core_q.pop_front();
            chk("core_rdata", core_rdata, e);
          end
        end
      end
    end
  end

  task automatic core_load(input logic [31:0] a, input logic [31:0] e);
    int stalls;
    bit done;
    step();
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    core_q.push_back(e);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (core_stall) stalls++;
      else done = 1'b1;
    end
    chk("load_done", 32'(done), 32'd1);
    chk("load_stalls", 32'(stalls), 32'd1);
    step();
    core_req = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_stall, exp_ready, exp_rvalid, dv;
    int first_ready;

    rst = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("in_reset");
    step();
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("idle");

    // Core store, then load back
    step();
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("store_mem_we", 32'(mem_we), 32'd1);
    chk("store_mem_addr", mem_addr, 32'h10);
    chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("store_stall", 32'(core_stall), 32'd0);
    step();
    core_req = 0;
    core_load(32'h10, 32'hDEADBEEF);

    // Debug write then read
    step();
    dbg_valid = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    @(negedge clk);
    chk("dbg_wr_ready", 32'(dbg_ready), 32'd1);
    chk("dbg_wr_mem_we", 32'(mem_we), 32'd1);
    step();
    dbg_valid = 0;
    @(negedge clk);
    chk("dbg_wr_ready_once", 32'(dbg_ready), 32'd0);
    step();
    dbg_valid = 1; dbg_we = 0; dbg_addr = 32'h20;
    dbg_q.push_back(32'h12345678);
    @(negedge clk);
    chk("dbg_rd_ready", 32'(dbg_ready), 32'd1);
    step();
    dbg_valid = 0;
    @(negedge clk);
    chk("dbg_rd_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("dbg_rd_ready_resp", 32'(dbg_ready), 32'd0);
    step();
    @(negedge clk);
    chk("dbg_rvalid_pulse", 32'(dbg_rvalid), 32'd0);

    // Starvation guard: continuous core loads, debug read held
    exp_stall  = 8'b0111_0101;
    exp_ready  = 8'b0001_0000;
    exp_rvalid = 8'b0010_0000;
    dv         = 8'b0001_1111;
    first_ready = -1;
    step();
    core_req = 1; core_we = 0; core_addr = 32'h10;
    dbg_valid = 1; dbg_we = 0; dbg_addr = 32'h20;
    repeat (3) core_q.push_back(32'hDEADBEEF);
    dbg_q.push_back(32'h12345678);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
        dbg_valid = dv[i];
      end
      @(negedge clk);
      chk($sformatf("starve_stall_%0d", i), 32'(core_stall), 32'(exp_stall[i]));
      chk($sformatf("starve_ready_%0d", i), 32'(dbg_ready), 32'(exp_ready[i]));
      chk($sformatf("starve_rvalid_%0d", i), 32'(dbg_rvalid), 32'(exp_rvalid[i]));
      if (dbg_ready && first_ready < 0) first_ready = i;
    end
    chk("starve_grant_cycle", 32'(first_ready), 32'd4);
    step();
    core_req = 0;

    // Simultaneous core store and debug read: core first
    step();
    core_req = 1; core_we = 1; core_addr = 32'h30; core_wdata = 32'hA5A5A5A5;
    dbg_valid = 1; dbg_we = 0; dbg_addr = 32'h10;
    dbg_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("conf_core_stall", 32'(core_stall), 32'd0);
    chk("conf_dbg_ready0", 32'(dbg_ready), 32'd0);
    chk("conf_mem_addr0", mem_addr, 32'h30);
    step();
    core_req = 0;
    @(negedge clk);
    chk("conf_dbg_ready1", 32'(dbg_ready), 32'd1);
    chk("conf_mem_addr1", mem_addr, 32'h10);
    step();
    dbg_valid = 0;
    @(negedge clk);
    chk("conf_rvalid", 32'(dbg_rvalid), 32'd1);
    core_load(32'h30, 32'hA5A5A5A5);

    // Reset during RESP_D drops the response
    step();
    dbg_valid = 1; dbg_we = 0; dbg_addr = 32'h20;
    @(negedge clk);
    chk("rst_rd_ready", 32'(dbg_ready), 32'd1);
    step();
    dbg_valid = 0;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rst_held0");
    step();
    @(negedge clk);
    chk_quiet("rst_held1");
    step();
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("rst_release");

`ifdef DMEM_ARB_STATS_EN
    chk("stat_core_reset", 32'(stat_core_grants), 32'd0);
    step();
    core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'h1;
    dbg_valid = 1; dbg_we = 1; dbg_addr = 32'h44; dbg_wdata = 32'h2;
    step();
    step();
    step();
    core_req = 0; dbg_valid = 0;
    for (int n = 0; n < 2; n++) begin
      step();
      dbg_valid = 1;
      step();
      dbg_valid = 0;
    end
    @(negedge clk);
    chk("stat_conflicts", 32'(stat_conflicts), 32'd3);
    chk("stat_dbg_grants", 32'(stat_dbg_grants), 32'd2);
    chk("stat_core_grants", 32'(stat_core_grants), 32'd3);
`endif

    repeat (3) step();
    chk("core_q_drained", 32'(core_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
